// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pixel clock-enable
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic          line_start,
    output logic          vblank
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        (64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_params
        $error("vga_timing_gen: porch/sync widths must be >= 1 and CW must hold the totals");
    end

    logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic          fs_q, fs_d, ls_q, ls_d, vb_q, vb_d;
    logic          h_last, v_last;

    // next counter values and decode of the pixel currently addressed by the counters
    always_comb begin
        h_last = (h_q == CW'(H_TOTAL - 1));
        v_last = (v_q == CW'(V_TOTAL - 1));
        h_d    = h_last ? '0 : h_q + 1'b1;
        v_d    = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
        act_d  = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
        x_d    = act_d ? h_q : '0;
        y_d    = act_d ? v_q : '0;
        hs_d   = (h_q >= CW'(H_SS) && h_q < CW'(H_SE)) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (v_q >= CW'(V_SS) && v_q < CW'(V_SE)) ? SYNC_POL : ~SYNC_POL;
        fs_d   = (h_q == '0) && (v_q == '0);
        ls_d   = (h_q == '0);
        vb_d   = (v_q >= CW'(V_ACTIVE));
    end

    // counters and aligned output register, all advancing only on pixel enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            act_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            vb_q  <= 1'b0;
        end else if (pix_ce) begin
            h_q   <= h_d;
            v_q   <= v_d;
            act_q <= act_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
            vb_q  <= vb_d;
        end
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign active      = act_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign vblank      = vb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random pixel-enable bench against an arithmetic raster model
module tb_vga_timing_gen;
    typedef struct packed {
        logic       hs, vs, act, fs, ls, vb;
        logic [9:0] x, y;
    } out_t;

    logic clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0;
    int   mode = 0, n = 0, checks = 0, fails = 0;
    bit   run = 1'b0;
    out_t ea, eb, ga, gb;

    logic hs_a, vs_a, act_a, fs_a, ls_a, vb_a;
    logic [4:0] x_a, y_a;
    logic hs_b, vs_b, act_b, fs_b, ls_b, vb_b;
    logic [3:0] x_b, y_b;

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(10), .V_FP(2),
                     .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .CW(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hsync(hs_a), .vsync(vs_a), .active(act_a),
        .x(x_a), .y(y_a), .frame_start(fs_a), .line_start(ls_a), .vblank(vb_a));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(5), .V_FP(1),
                     .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b1), .CW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .hsync(hs_b), .vsync(vs_b), .active(act_b),
        .x(x_b), .y(y_b), .frame_start(fs_b), .line_start(ls_b), .vblank(vb_b));

    always #5 clk = ~clk;

    function automatic out_t dec(int k, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb, bit pol);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h = k % ht;
        int v = (k / ht) % vt;
        out_t o;
        o.act = (h < ha) && (v < va);
        o.x   = o.act ? 10'(h) : 10'd0;
        o.y   = o.act ? 10'(v) : 10'd0;
        o.hs  = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
        o.vs  = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
        o.fs  = (h == 0) && (v == 0);
        o.ls  = (h == 0);
        o.vb  = (v >= va);
        return o;
    endfunction

    function automatic out_t rst_val(bit pol);
        out_t o = '0;
        o.hs = !pol;
        o.vs = !pol;
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // pixel-enable driver: 0 = always on, 1 = divide by two, 2 = random
    initial forever begin
        @(posedge clk);
        #2;
        pix_ce = (mode == 0) ? 1'b1 : (mode == 1) ? ~pix_ce : 1'($urandom_range(0, 1));
    end

    // model: output k-th pixel on the k-th enabled edge since reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n  = 0;
            ea = rst_val(1'b0);
            eb = rst_val(1'b1);
        end else if (pix_ce) begin
            ea = dec(n, 16, 2, 3, 4, 10, 2, 2, 3, 1'b0);
            eb = dec(n, 8, 1, 2, 1, 5, 1, 1, 2, 1'b1);
            n++;
        end
    end

    assign ga = '{hs_a, vs_a, act_a, fs_a, ls_a, vb_a, 10'(x_a), 10'(y_a)};
    assign gb = '{hs_b, vs_b, act_b, fs_b, ls_b, vb_b, 10'(x_b), 10'(y_b)};

    initial forever begin
        @(negedge clk);
        if (run) begin
            checks += 2;
            if (ga !== ea) begin
                fails++;
                $display("FAIL model_a: got %h expected %h at %0t", ga, ea, $time);
            end
            if (gb !== eb) begin
                fails++;
                $display("FAIL model_b: got %h expected %h at %0t", gb, eb, $time);
            end
        end
    end

    task automatic measure(input int div);
        int cnt = 0, hi = 1, vlo, hlo, ls, vbc;
        logic prev = fs_a;
        while (!(fs_a && !prev) && cnt < 2000) begin
            prev = fs_a;
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 2000) check("fs_wait_timeout", 0, 1);
        vlo = !vs_a; hlo = !hs_a; ls = ls_a; vbc = vb_a;
        prev = 1'b1;
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (fs_a && !prev) break;
            hi += fs_a; vlo += !vs_a; hlo += !hs_a; ls += ls_a; vbc += vb_a;
            prev = fs_a;
        end
        check("frame_period", cnt, 425 * div);
        check("fs_width", hi, div);
        check("vsync_low", vlo, 50 * div);
        check("hsync_low", hlo, 51 * div);
        check("line_starts", ls, 17 * div);
        check("vblank_len", vbc, 175 * div);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #1;
        check("first_act", act_a, 1);
        check("first_x", x_a, 0);
        check("first_y", y_a, 0);
        check("first_fs", fs_a, 1);
        check("first_ls", ls_a, 1);
        check("first_hs", hs_a, 1);
        check("first_vs", vs_a, 1);
        check("first_hs_b", hs_b, 0);
        measure(1);
        measure(1);
        t = 0;
        while (!(x_a == 5'd15 && y_a == 5'd9) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("last_pix_act", act_a, 1);
        check("last_pix_xy", {x_a, y_a}, {5'd15, 5'd9});
        mode = 1;
        measure(2);
        mode = 2;
        repeat (1500) @(posedge clk);
        mode = 0;
        t = 0;
        while (y_a != 5'd4 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check("mid_frame_reached", y_a, 4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_act", act_a, 0);
        check("rst_xy", {x_a, y_a}, 0);
        check("rst_strobes", {fs_a, ls_a, vb_a}, 0);
        check("rst_sync_a", {hs_a, vs_a}, 2'b11);
        check("rst_sync_b", {hs_b, vs_b}, 2'b00);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_fs", fs_a, 1);
        check("restart_act", act_a, 1);
        check("restart_xy", {x_a, y_a}, 0);
        mode = 2;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
